// File: rtl/ledpanel_capture.sv
// ledpanel_capture: receive-side RGB LED panel model that rebuilds a 32x16 3-bit frame from the panel drive pins
// and flags protocol violations (short/long lines, copy overrun, OE during latch).
module ledpanel_capture #(
    parameter int SYNC_STAGES     = 2,
    parameter int FRAME_CNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [2:0]                 led_rgb1,
    input  logic [2:0]                 led_rgb2,
    input  logic [2:0]                 led_abc,
    input  logic                       led_clk,
    input  logic                       led_latch,
    input  logic                       led_oe,
    input  logic [4:0]                 rd_x,
    input  logic [3:0]                 rd_y,
    output logic [2:0]                 rd_color,
    output logic                       frame_done,
    output logic [FRAME_CNT_WIDTH-1:0] frame_count,
    output logic                       err_short,
    output logic                       err_long,
    output logic                       err_overrun,
    output logic                       err_oe,
    input  logic                       err_clear
);
    typedef enum logic {SHIFT, COPY} state_t;
    localparam logic [2:0] ROW_MAP [8] = '{3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7, 3'd0};
    localparam logic [FRAME_CNT_WIDTH-1:0] CNT_ONE = 1;
    state_t state, state_next;
    logic [11:0] pins;
    logic [11:0] sync_q [SYNC_STAGES];
    logic [11:0] d;
    logic prev_clk, prev_latch;
    logic clk_rise, latch_rise, shift_ok, copy_last;
    logic [5:0] shift_count, shift_count_upd;
    logic [4:0] k;
    logic [2:0] row;
    logic last_row;
    logic [2:0] top_buf [32];
    logic [2:0] bot_buf [32];
    logic [2:0] mem_top [256];
    logic [2:0] mem_bot [256];
    // d is the aligned copy of every pin; prev_* lag it by one cycle for edge detection
    assign pins = {led_rgb1, led_rgb2, led_abc, led_clk, led_latch, led_oe};
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            d          <= '0;
            prev_clk   <= 1'b0;
            prev_latch <= 1'b0;
        end else begin
            sync_q[0] <= pins;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            d          <= sync_q[SYNC_STAGES-1];
            prev_clk   <= d[2];
            prev_latch <= d[1];
        end
    end
    assign clk_rise        = d[2] & ~prev_clk;
    assign latch_rise      = d[1] & ~prev_latch;
    assign shift_ok        = (state == SHIFT) && clk_rise && !shift_count[5];
    assign shift_count_upd = shift_count + {5'd0, shift_ok};
    assign copy_last       = (state == COPY) && (&k);
    always_ff @(posedge clk) begin
        if (!reset) state <= SHIFT;
        else        state <= state_next;
    end
    always_comb begin
        state_next = state;
        if (state == SHIFT) state_next = latch_rise ? COPY : SHIFT;
        else                state_next = (&k) ? SHIFT : COPY;
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            shift_count <= '0;
            k           <= '0;
            row         <= '0;
            last_row    <= 1'b0;
            frame_done  <= 1'b0;
            frame_count <= '0;
            rd_color    <= '0;
            err_short   <= 1'b0;
            err_long    <= 1'b0;
            err_overrun <= 1'b0;
            err_oe      <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            rd_color   <= rd_y[3] ? mem_bot[{rd_y[2:0], rd_x}] : mem_top[{rd_y[2:0], rd_x}];
            if (state == SHIFT) begin
                shift_count <= shift_count_upd;
                if (latch_rise) begin
                    row      <= ROW_MAP[d[5:3]];
                    last_row <= &d[5:3];
                    k        <= '0;
                end
            end else begin
                k <= k + 5'd1;
                if (&k) begin
                    shift_count <= '0;
                    if (last_row) begin
                        frame_done  <= 1'b1;
                        frame_count <= frame_count + CNT_ONE;
                    end
                end
            end
            err_short   <= !err_clear && (err_short || ((state == SHIFT) && latch_rise && !shift_count_upd[5]));
            err_long    <= !err_clear && (err_long || ((state == SHIFT) && clk_rise && shift_count[5]));
            err_overrun <= !err_clear && (err_overrun || ((state == COPY) && (clk_rise || latch_rise)));
            err_oe      <= !err_clear && (err_oe || (!d[0] && d[1]));
        end
    end
    // Line buffers and frame memory carry no reset; columns past shift_count are masked to black on copy
    always_ff @(posedge clk) begin
        if (reset && shift_ok) begin
            top_buf[shift_count[4:0]] <= d[11:9];
            bot_buf[shift_count[4:0]] <= d[8:6];
        end
        if (reset && (state == COPY)) begin
            mem_top[{row, k}] <= ({1'b0, k} < shift_count) ? top_buf[k] : 3'b000;
            mem_bot[{row, k}] <= ({1'b0, k} < shift_count) ? bot_buf[k] : 3'b000;
        end
    end
endmodule

// File: tb/tb_ledpanel_capture.sv
// tb_ledpanel_capture: directed panel-drive stimulus with a scoreboard of expected pixel reads and frame_done events.
module tb_ledpanel_capture;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [2:0] led_rgb1 = '0, led_rgb2 = '0, led_abc = '0;
    logic led_clk = 1'b0, led_latch = 1'b0, led_oe = 1'b1;
    logic [4:0] rd_x = '0;
    logic [3:0] rd_y = '0;
    logic err_clear = 1'b0;
    logic [2:0] rd_color, rd_color2;
    logic frame_done, frame_done2;
    logic [15:0] frame_count;
    logic [1:0] frame_count2;
    logic err_short, err_long, err_overrun, err_oe;
    logic e2_short, e2_long, e2_overrun, e2_oe;
    int checks = 0;
    int errors = 0;
    int exp_frames = 0;
    logic [2:0] rd_q [$];
    logic [15:0] fd_q [$];
    logic rd_req = 1'b0;
    logic rd_pend = 1'b0;
    int row_map [8] = '{4, 2, 6, 1, 5, 3, 7, 0};
    localparam int E = 3;
    always #5 clk = ~clk;
    ledpanel_capture dut (
        .clk(clk), .reset(reset), .led_rgb1(led_rgb1), .led_rgb2(led_rgb2), .led_abc(led_abc),
        .led_clk(led_clk), .led_latch(led_latch), .led_oe(led_oe), .rd_x(rd_x), .rd_y(rd_y),
        .rd_color(rd_color), .frame_done(frame_done), .frame_count(frame_count),
        .err_short(err_short), .err_long(err_long), .err_overrun(err_overrun), .err_oe(err_oe),
        .err_clear(err_clear)
    );
    ledpanel_capture #(.FRAME_CNT_WIDTH(2)) dut2 (
        .clk(clk), .reset(reset), .led_rgb1(led_rgb1), .led_rgb2(led_rgb2), .led_abc(led_abc),
        .led_clk(led_clk), .led_latch(led_latch), .led_oe(led_oe), .rd_x(rd_x), .rd_y(rd_y),
        .rd_color(rd_color2), .frame_done(frame_done2), .frame_count(frame_count2),
        .err_short(e2_short), .err_long(e2_long), .err_overrun(e2_overrun), .err_oe(e2_oe),
        .err_clear(err_clear)
    );
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask
    task automatic check_flags(input string name, input logic [3:0] exp);
        check(name, {28'd0, err_short, err_long, err_overrun, err_oe}, {28'd0, exp});
        check({name, "_w2"}, {28'd0, e2_short, e2_long, e2_overrun, e2_oe}, {28'd0, exp});
    endtask
    // Monitor: pops the scoreboard whenever the DUT presents a read result or a frame_done pulse
    always @(posedge clk) rd_pend <= rd_req;
    always @(negedge clk) begin
        if (rd_pend) begin
            if (rd_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL rd_scoreboard: read result with no expected entry");
            end else begin
                check("rd_color", {29'd0, rd_color}, {29'd0, rd_q[0]});
                check("rd_color_w2", {29'd0, rd_color2}, {29'd0, rd_q[0]});
                void'(rd_q.pop_front());
            end
        end
        if (frame_done) begin
            if (fd_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL frame_done: unexpected pulse, frame_count %0d", frame_count);
            end else check("frame_count_at_done", {16'd0, frame_count}, {16'd0, fd_q.pop_front()});
        end
    end
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic shift(input logic [2:0] a, input logic [2:0] b);
        led_rgb1 = a; led_rgb2 = b; led_clk = 1'b1;
        tick(2);
        led_clk = 1'b0;
        tick(2);
    endtask
    task automatic latch(input logic [2:0] abc);
        led_abc = abc; led_latch = 1'b1;
        if (abc == 3'd7) begin
            exp_frames++;
            fd_q.push_back(16'(exp_frames));
        end
        tick(2);
        led_latch = 1'b0;
        tick(40);
    endtask
    task automatic rd(input int x, input int y, input logic [2:0] exp);
        rd_x = 5'(x); rd_y = 4'(y); rd_req = 1'b1;
        rd_q.push_back(exp);
        tick(1);
    endtask
    task automatic rd_done();
        rd_req = 1'b0;
        tick(3);
    endtask
    task automatic clear_errors();
        err_clear = 1'b1;
        tick(1);
        err_clear = 1'b0;
    endtask
    initial begin
        int first_edge, pulses, pulses2;
        tick(3);
        check("reset_rd_color", {29'd0, rd_color}, 0);
        check("reset_frame_done", {31'd0, frame_done}, 0);
        check("reset_frame_count", {16'd0, frame_count}, 0);
        check_flags("reset_flags", 4'b0000);
        reset = 1'b1;
        tick(2);
        // Full frame: pixel (x+abc) mod 8 in both halves
        for (int a = 0; a < 8; a++) begin
            for (int x = 0; x < 32; x++) shift(3'((x + a) % 8), 3'((x + a) % 8));
            latch(3'(a));
        end
        check("frame_count_full", {16'd0, frame_count}, 1);
        check("frame_count_w2_1", {30'd0, frame_count2}, 1);
        check_flags("full_flags", 4'b0000);
        for (int a = 0; a < 8; a++)
            for (int x = 0; x < 32; x++) begin
                rd(x, row_map[a], 3'((x + a) % 8));
                rd(x, row_map[a] + 8, 3'((x + a) % 8));
            end
        rd_done();
        // Wrap of the 2-bit counter: frames 2..5 as bare abc=7 latches
        for (int f = 2; f <= 5; f++) begin
            latch(3'd7);
            check("frame_count_main", {16'd0, frame_count}, 32'(f));
            check("frame_count_w2", {30'd0, frame_count2}, 32'(f % 4));
        end
        check_flags("wrap_flags_short", 4'b1000);
        clear_errors();
        check_flags("wrap_flags_cleared", 4'b0000);
        // Row mapping: abc=3 lands on rows 1 and 9
        for (int x = 0; x < 32; x++) shift(3'b101, 3'b010);
        latch(3'd3);
        check_flags("map_flags", 4'b0000);
        for (int x = 0; x < 32; x++) begin
            rd(x, 1, 3'd5);
            rd(x, 9, 3'd2);
        end
        rd_done();
        // Short line: 20 shifts of 7 at abc=0 (row 4)
        for (int x = 0; x < 20; x++) shift(3'd7, 3'd7);
        latch(3'd0);
        check_flags("short_flags", 4'b1000);
        for (int x = 0; x < 32; x++) begin
            rd(x, 4, (x < 20) ? 3'd7 : 3'd0);
            rd(x, 12, (x < 20) ? 3'd7 : 3'd0);
        end
        rd_done();
        clear_errors();
        // Long line plus a shift edge at E+10 of the latch
        for (int x = 0; x < 33; x++) shift(3'd1, 3'd6);
        led_abc = 3'd1; led_latch = 1'b1;
        tick(2);
        led_latch = 1'b0;
        tick(8);
        led_clk = 1'b1;
        tick(2);
        led_clk = 1'b0;
        tick(40);
        check_flags("long_overrun_flags", 4'b0110);
        for (int x = 0; x < 32; x++) begin
            rd(x, 2, 3'd1);
            rd(x, 10, 3'd6);
        end
        rd_done();
        led_abc = 3'd2; led_oe = 1'b0; led_latch = 1'b1;
        tick(5);
        check("err_oe_set", {31'd0, err_oe}, 1);
        led_latch = 1'b0; led_oe = 1'b1;
        tick(40);
        check_flags("all_flags", 4'b1111);
        clear_errors();
        check_flags("cleared_next_cycle", 4'b0000);
        // Timing of frame_done relative to latch detection at E
        led_abc = 3'd7; led_latch = 1'b1;
        exp_frames++;
        fd_q.push_back(16'(exp_frames));
        first_edge = -1; pulses = 0; pulses2 = 0;
        for (int i = 0; i < 45; i++) begin
            @(posedge clk);
            #1;
            if (i == 2) led_latch = 1'b0;
            if (frame_done) begin
                pulses++;
                if (first_edge < 0) first_edge = i + 1;
            end
            if (frame_done2) pulses2++;
        end
        check("frame_done_edge", 32'(first_edge), E + 33);
        check("frame_done_pulses", 32'(pulses), 1);
        check("frame_done_pulses_w2", 32'(pulses2), 1);
        check("frame_count_timing", {16'd0, frame_count}, 32'(exp_frames));
        tick(5);
        // Reset at E+15 of an abc=7 latch abandons the row
        led_abc = 3'd7; led_latch = 1'b1;
        tick(3);
        led_latch = 1'b0;
        tick(15);
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
        exp_frames = 0;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (frame_done) pulses++;
        end
        check("reset_no_frame_done", 32'(pulses), 0);
        check("reset_frame_count_0", {16'd0, frame_count}, 0);
        check("reset_frame_count_w2", {30'd0, frame_count2}, 0);
        check_flags("after_reset_flags", 4'b0000);
        for (int x = 0; x < 32; x++) shift(3'd6, 3'd3);
        latch(3'd5);
        check_flags("post_reset_line_flags", 4'b0000);
        for (int x = 0; x < 32; x++) begin
            rd(x, 3, 3'd6);
            rd(x, 11, 3'd3);
        end
        rd_done();
        check("rd_queue_drained", 32'(rd_q.size()), 0);
        check("fd_queue_drained", 32'(fd_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
